// File: rtl/mouse_status_reg_pkg.sv
// Shared definitions for the PS/2 mouse status register block: packet FSM
// state encoding, register window offsets and FLAGS bit positions.
package mouse_status_reg_pkg;

  // Packet assembler states
  localparam logic [1:0] ST_WAIT_STATUS = 2'd0;
  localparam logic [1:0] ST_WAIT_DX     = 2'd1;
  localparam logic [1:0] ST_WAIT_DY     = 2'd2;

  // Register offsets from the window base
  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_DX     = 2'd1;
  localparam logic [1:0] OFF_DY     = 2'd2;
  localparam logic [1:0] OFF_FLAGS  = 2'd3;

  // FLAGS bit indices
  localparam int FLAG_READY    = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_RX_ERROR = 2;
  localparam int FLAG_RESYNC   = 3;

  // Only the low four FLAGS bits exist; the rest always read 0
  localparam logic [7:0] FLAG_MASK = 8'h0F;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
  } mouse_pkt_t;

endpackage

// File: rtl/mouse_packet_fsm.sv
// Assembles three-byte PS/2 mouse packets into staging registers and pulses
// commit for one cycle once the DY byte has been captured.
//
//   state          | meaning
//   ---------------+-----------------------------------------------------
//   WAIT_STATUS    | idle; waiting for a status byte (bit 3 set)
//   WAIT_DX        | status staged; waiting for the X movement byte
//   WAIT_DY        | DX staged; waiting for the Y movement byte
module mouse_packet_fsm
  import mouse_status_reg_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       byte_error,
  output mouse_pkt_t pkt,
  output logic       commit,
  output logic       rx_error,
  output logic       resync
);

  logic [1:0]  state;
  logic [23:0] gap_cnt;
  logic        busy;

  assign busy = (state != ST_WAIT_STATUS);

  // Timeout fires on the edge where the gap counter would reach TIMEOUT;
  // a byte or error arriving on that same edge takes precedence.
  assign resync   = busy && !byte_valid && !byte_error && (gap_cnt == TIMEOUT - 24'd1);
  assign rx_error = byte_error;

  // Packet FSM, staging registers, inter-byte counter and commit strobe
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_WAIT_STATUS;
      pkt     <= '0;
      gap_cnt <= '0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (byte_error) begin
        state   <= ST_WAIT_STATUS;
        pkt     <= '0;
        gap_cnt <= '0;
      end else if (byte_valid) begin
        gap_cnt <= '0;
        case (state)
          ST_WAIT_STATUS: begin
            if (byte_in[3]) begin
              pkt.status <= byte_in;
              state      <= ST_WAIT_DX;
            end
          end
          ST_WAIT_DX: begin
            pkt.dx <= byte_in;
            state  <= ST_WAIT_DY;
          end
          ST_WAIT_DY: begin
            pkt.dy <= byte_in;
            state  <= ST_WAIT_STATUS;
            commit <= 1'b1;
          end
          default: state <= ST_WAIT_STATUS;
        endcase
      end else if (resync) begin
        state   <= ST_WAIT_STATUS;
        gap_cnt <= '0;
      end else if (busy) begin
        gap_cnt <= gap_cnt + 24'd1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mouse_status_reg.sv
// Bus-visible mouse register window: STATUS/DX/DY/FLAGS at base+0..3,
// interrupt request for completed packets, registered tristate read port.
module mouse_status_reg
  import mouse_status_reg_pkg::*;
#(
  parameter logic [7:0]  MouseBaseAddr = 8'hA0,
  parameter logic [23:0] TIMEOUT       = 24'd5_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERROR,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  mouse_pkt_t stg_pkt;
  mouse_pkt_t pkt_q;
  logic       commit;
  logic       rx_error;
  logic       resync;
  logic [7:0] flags;
  logic [7:0] flag_set;
  logic [7:0] flag_clr;
  logic [7:0] addr_off;
  logic       in_window;
  logic       tx_en;
  logic [1:0] rd_idx;
  logic [7:0] rd_data;

  mouse_packet_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .CLK        (CLK),
    .RESET      (RESET),
    .byte_in    (BYTE_IN),
    .byte_valid (BYTE_VALID),
    .byte_error (BYTE_ERROR),
    .pkt        (stg_pkt),
    .commit     (commit),
    .rx_error   (rx_error),
    .resync     (resync)
  );

  // Offset subtraction wraps, so any base value works without alignment
  assign addr_off  = BUS_ADDR - MouseBaseAddr;
  assign in_window = (addr_off[7:2] == 6'd0);

  // Flag set/clear requests for this cycle; set beats a simultaneous clear
  always_comb begin
    flag_set                = '0;
    flag_set[FLAG_READY]    = commit;
    flag_set[FLAG_OVERFLOW] = commit && BUS_INTERRUPT_RAISE;
    flag_set[FLAG_RX_ERROR] = rx_error;
    flag_set[FLAG_RESYNC]   = resync;
    flag_clr                = '0;
    if (BUS_WE && in_window && (addr_off[1:0] == OFF_FLAGS))
      flag_clr = BUS_DATA;
  end

  // Packet registers, FLAGS and interrupt level
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pkt_q               <= '0;
      flags               <= '0;
      BUS_INTERRUPT_RAISE <= 1'b0;
    end else begin
      if (commit)
        pkt_q <= stg_pkt;
      flags <= ((flags & ~flag_clr) | flag_set) & FLAG_MASK;
      if (commit)
        BUS_INTERRUPT_RAISE <= 1'b1;
      else if (BUS_INTERRUPT_ACK)
        BUS_INTERRUPT_RAISE <= 1'b0;
    end
  end

  // Read request is registered; data is driven the following cycle
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tx_en  <= 1'b0;
      rd_idx <= '0;
    end else begin
      tx_en  <= !BUS_WE && in_window;
      rd_idx <= addr_off[1:0];
    end
  end

  // Read mux reflects register contents in the drive cycle
  always_comb begin
    rd_data = '0;
    case (rd_idx)
      OFF_STATUS: rd_data = pkt_q.status;
      OFF_DX:     rd_data = pkt_q.dx;
      OFF_DY:     rd_data = pkt_q.dy;
      OFF_FLAGS:  rd_data = flags;
      default:    rd_data = '0;
    endcase
  end

  assign BUS_DATA = tx_en ? rd_data : 8'bz;

endmodule

// File: tb/tb_mouse_status_reg.sv
// Self-checking bench for mouse_status_reg: bus reads are scoreboarded,
// expected bytes queued when the read is issued and compared when driven.
module tb_mouse_status_reg;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] BUS_ADDR = 8'h00;
  logic       BUS_WE = 1'b0;
  logic [7:0] BYTE_IN = 8'h00;
  logic       BYTE_VALID = 1'b0;
  logic       BYTE_ERROR = 1'b0;
  logic       BUS_INTERRUPT_ACK = 1'b0;
  logic       BUS_INTERRUPT_RAISE;
  wire  [7:0] BUS_DATA;

  logic [7:0] tb_drv = 8'h00;
  logic       tb_oe = 1'b0;
  assign BUS_DATA = tb_oe ? tb_drv : 8'bz;

  wire bus_is_z = (BUS_DATA === 8'bz);

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  logic       rd_req = 1'b0;
  logic       rd_seen;
  logic [8:0] sb_exp;
  string      sb_tag;

  mouse_status_reg #(
    .MouseBaseAddr (8'hA0),
    .TIMEOUT       (24'd100)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .BUS_DATA            (BUS_DATA),
    .BUS_ADDR            (BUS_ADDR),
    .BUS_WE              (BUS_WE),
    .BYTE_IN             (BYTE_IN),
    .BYTE_VALID          (BYTE_VALID),
    .BYTE_ERROR          (BYTE_ERROR),
    .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
    .BUS_INTERRUPT_ACK   (BUS_INTERRUPT_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Data for a read issued before this edge is driven just after it
  always @(posedge CLK) begin
    rd_seen = rd_req;
    #2;
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 8'(exp_q.size()), 8'd1);
      end else begin
        sb_exp = exp_q.pop_front();
        sb_tag = tag_q.pop_front();
        if (sb_exp[8])
          check_eq({sb_tag, "_z"}, {7'b0, bus_is_z}, 8'd1);
        else
          check_eq(sb_tag, BUS_DATA, sb_exp[7:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    BYTE_IN = b;
    BYTE_VALID = 1'b1;
    @(negedge CLK);
    BYTE_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string t);
    BUS_ADDR = a;
    BUS_WE = 1'b0;
    rd_req = 1'b1;
    exp_q.push_back({1'b0, e});
    tag_q.push_back(t);
    @(negedge CLK);
    rd_req = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic rd_z(input logic [7:0] a, input string t);
    BUS_ADDR = a;
    BUS_WE = 1'b0;
    rd_req = 1'b1;
    exp_q.push_back({1'b1, 8'h00});
    tag_q.push_back(t);
    @(negedge CLK);
    rd_req = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  // One idle cycle first so the DUT has released the bus
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    BUS_ADDR = a;
    BUS_WE = 1'b1;
    tb_drv = d;
    tb_oe = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
    tb_oe = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic ack();
    BUS_INTERRUPT_ACK = 1'b1;
    @(negedge CLK);
    BUS_INTERRUPT_ACK = 1'b0;
  endtask

  task automatic err();
    BYTE_ERROR = 1'b1;
    @(negedge CLK);
    BYTE_ERROR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check_eq("rst_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    check_eq("rst_bus_z", {7'b0, bus_is_z}, 8'h01);
    idle(3);
    RESET = 1'b1;
    idle(1);
    rd(8'hA0, 8'h00, "rst_status");
    rd(8'hA1, 8'h00, "rst_dx");
    rd(8'hA2, 8'h00, "rst_dy");
    rd(8'hA3, 8'h00, "rst_flags");

    // Basic packet with gaps between bytes
    send(8'h08); idle(10);
    send(8'h05); idle(10);
    send(8'hFB);
    rd(8'hA0, 8'h08, "p1_status");
    rd(8'hA1, 8'h05, "p1_dx");
    rd(8'hA2, 8'hFB, "p1_dy");
    rd(8'hA3, 8'h01, "p1_flags");
    check_eq("p1_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h01);
    ack();
    check_eq("p1_ack", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    wr(8'hA3, 8'h01);
    rd(8'hA3, 8'h00, "p1_w1c");

    // Leading byte without bit 3 is dropped
    send(8'h00); send(8'h09); send(8'h01); send(8'h02);
    rd(8'hA0, 8'h09, "p2_status");
    rd(8'hA1, 8'h01, "p2_dx");
    rd(8'hA2, 8'h02, "p2_dy");
    rd(8'hA3, 8'h01, "p2_flags");

    // Second packet while first is pending: overflow, overwrite
    send(8'h0C); send(8'h11); send(8'h22);
    rd(8'hA0, 8'h0C, "ovf_status");
    rd(8'hA1, 8'h11, "ovf_dx");
    rd(8'hA2, 8'h22, "ovf_dy");
    rd(8'hA3, 8'h03, "ovf_flags");
    ack();
    check_eq("ovf_ack", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    wr(8'hA2, 8'hFF);
    rd(8'hA2, 8'h22, "ro_dy");
    wr(8'hA3, 8'h03);
    rd(8'hA3, 8'h00, "ovf_w1c");

    // Receive error mid-packet
    send(8'h09); send(8'h01);
    err();
    rd(8'hA3, 8'h04, "err_flags");
    rd(8'hA0, 8'h0C, "err_status_kept");
    rd(8'hA2, 8'h22, "err_dy_kept");
    send(8'h0A); send(8'h02); send(8'h03);
    rd(8'hA0, 8'h0A, "err_next_status");
    rd(8'hA1, 8'h02, "err_next_dx");
    rd(8'hA2, 8'h03, "err_next_dy");
    rd(8'hA3, 8'h05, "err_next_flags");
    ack();
    wr(8'hA3, 8'h0F);
    rd(8'hA3, 8'h00, "err_w1c");

    // Inter-byte timeout: flag appears exactly 100 cycles after the status byte
    send(8'h09);
    idle(98);
    rd(8'hA3, 8'h00, "to_cycle99");
    rd(8'hA3, 8'h08, "to_cycle100");
    send(8'h01); send(8'h02);
    idle(2);
    rd(8'hA0, 8'h0A, "to_no_commit_status");
    rd(8'hA1, 8'h02, "to_no_commit_dx");
    rd(8'hA3, 8'h08, "to_flags_hold");
    check_eq("to_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    wr(8'hA3, 8'h08);

    // ACK on the commit cycle loses to the commit
    send(8'h0D); send(8'h21); send(8'h42);
    ack();
    check_eq("ackcommit_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h01);
    rd(8'hA3, 8'h01, "ackcommit_flags");
    rd(8'hA0, 8'h0D, "ackcommit_status");

    // Asynchronous reset mid-packet while the bus is being driven
    send(8'h09); send(8'h01);
    BUS_ADDR = 8'hA0;
    BUS_WE = 1'b0;
    @(negedge CLK);
    check_eq("prerst_drive", BUS_DATA, 8'h0D);
    #2;
    RESET = 1'b0;
    #1;
    check_eq("midrst_bus_z", {7'b0, bus_is_z}, 8'h01);
    check_eq("midrst_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    BUS_ADDR = 8'h00;
    send(8'h05); send(8'h06);
    idle(2);
    rd(8'hA0, 8'h00, "postrst_status");
    rd(8'hA1, 8'h00, "postrst_dx");
    rd(8'hA2, 8'h00, "postrst_dy");
    rd(8'hA3, 8'h00, "postrst_flags");
    check_eq("postrst_raise", {7'b0, BUS_INTERRUPT_RAISE}, 8'h00);

    // Addresses outside the window leave the bus released
    rd_z(8'h80, "out_80");
    rd_z(8'hA4, "out_A4");
    rd_z(8'h9F, "out_9F");

    idle(3);
    check_eq("sb_drain", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
